wifi_mac_hdr_rx: RTL and testbench

//  Receive-side 802.11 MAC header parser. Consumes the byte stream of one MPDU and

---
 rtl/wifi_mac_hdr_rx.sv | 193 +++++++++++++++++++
 tb/tb_wifi_mac_hdr_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_mac_hdr_rx.sv
// Receive-side 802.11 MAC header parser.
// Splits one MPDU byte stream into decoded header fields and a payload stream.
module wifi_mac_hdr_rx #(
    parameter bit ADDR4_EN   = 1'b1,
    parameter bit STRICT_VER = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        hdr_valid,
    output logic [1:0]  fc_ver,
    output logic [1:0]  fc_type,
    output logic [3:0]  fc_subtype,
    output logic [7:0]  fc_flags,
    output logic [15:0] dur_id,
    output logic [47:0] addr1,
    output logic [47:0] addr2,
    output logic [47:0] addr3,
    output logic [47:0] addr4,
    output logic [15:0] seq_ctl,
    output logic        hdr_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_e;

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [239:0] sh_q, sh_d;
    logic         m_valid_q, m_last_q;
    logic [7:0]   m_data_q;
    logic         hv_q, he_q;
    logic [1:0]   err_q, err_d;
    logic [15:0]  fc_q, dur_q, seq_q;
    logic [47:0]  a1_q, a2_q, a3_q, a4_q;

    logic       rdy, acc, load_hdr, err_set;
    logic       four_addr, bad_ver, bad_type, bad_4a;
    logic [4:0] hdr_len;

    // Ready per state; the payload slice only accepts when it can hand off
    always_comb begin
        rdy = 1'b1;
        if (state_q == PAYLOAD) rdy = m_ready | ~m_valid_q;
    end

    assign s_ready = rst_n & rdy;
    assign acc     = s_valid & s_ready;

    // Next-state, header byte capture and error classification
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        load_hdr  = 1'b0;
        err_set   = 1'b0;
        err_d     = err_q;
        four_addr = sh_q[8] & sh_q[9];
        hdr_len   = four_addr ? 5'd30 : 5'd24;
        bad_ver   = STRICT_VER && (sh_q[1:0] != 2'b00);
        bad_type  = (sh_q[3:2] == 2'b01);
        bad_4a    = !ADDR4_EN && s_data[0] && s_data[1];
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    sh_d[7:0] = s_data;
                    if (s_last) begin
                        err_set = 1'b1;
                        err_d   = 2'd1;
                    end else begin
                        state_d = HDR;
                        cnt_d   = 5'd1;
                    end
                end
            end
            HDR: begin
                if (acc) begin
                    for (int i = 1; i < 30; i++) begin
                        if (cnt_q == 5'(i)) sh_d[i*8 +: 8] = s_data;
                    end
                    if (cnt_q < hdr_len) cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd1) begin
                        if (bad_ver || bad_type || bad_4a) begin
                            err_set = 1'b1;
                            err_d   = bad_ver ? 2'd2 : 2'd3;
                            state_d = s_last ? IDLE : DROP;
                        end else if (s_last) begin
                            err_set = 1'b1;
                            err_d   = 2'd1;
                            state_d = IDLE;
                        end
                    end else if (cnt_q == hdr_len - 5'd1) begin
                        load_hdr = 1'b1;
                        state_d  = s_last ? IDLE : PAYLOAD;
                    end else if (s_last) begin
                        err_set = 1'b1;
                        err_d   = 2'd1;
                        state_d = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (acc && s_last) state_d = IDLE;
            end
            DROP: begin
                if (acc && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, byte counter and header shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // Payload output register slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (acc && state_q == PAYLOAD) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_data;
            m_last_q  <= s_last;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Decoded header fields, status pulses and sticky error code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q  <= '0;
            dur_q <= '0;
            a1_q  <= '0;
            a2_q  <= '0;
            a3_q  <= '0;
            a4_q  <= '0;
            seq_q <= '0;
            hv_q  <= 1'b0;
            he_q  <= 1'b0;
            err_q <= '0;
        end else begin
            hv_q <= load_hdr;
            he_q <= err_set;
            if (err_set) err_q <= err_d;
            if (load_hdr) begin
                fc_q  <= sh_d[15:0];
                dur_q <= sh_d[31:16];
                a1_q  <= sh_d[79:32];
                a2_q  <= sh_d[127:80];
                a3_q  <= sh_d[175:128];
                seq_q <= sh_d[191:176];
                a4_q  <= four_addr ? sh_d[239:192] : '0;
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign hdr_valid  = hv_q;
    assign hdr_err    = he_q;
    assign err_code   = err_q;
    assign fc_ver     = fc_q[1:0];
    assign fc_type    = fc_q[3:2];
    assign fc_subtype = fc_q[7:4];
    assign fc_flags   = fc_q[15:8];
    assign dur_id     = dur_q;
    assign addr1      = a1_q;
    assign addr2      = a2_q;
    assign addr3      = a3_q;
    assign addr4      = a4_q;
    assign seq_ctl    = seq_q;

endmodule

// File: tb/tb_wifi_mac_hdr_rx.sv
// Directed bench for wifi_mac_hdr_rx.
// Drives byte frames, collects payload and header pulses, checks by assertion.
module tb_wifi_mac_hdr_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready;
    logic        hdr_valid, hdr_err;
    logic [1:0]  fc_ver, fc_type, err_code;
    logic [3:0]  fc_subtype;
    logic [7:0]  fc_flags;
    logic [15:0] dur_id, seq_ctl;
    logic [47:0] addr1, addr2, addr3, addr4;

    wifi_mac_hdr_rx dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .hdr_valid(hdr_valid), .fc_ver(fc_ver), .fc_type(fc_type),
        .fc_subtype(fc_subtype), .fc_flags(fc_flags), .dur_id(dur_id),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .seq_ctl(seq_ctl), .hdr_err(hdr_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int hv_cnt = 0, he_cnt = 0, both_cnt = 0, mv_cnt = 0;
    int stall_bad = 0, waits = 0;
    bit rnd = 1'b0;
    logic [8:0] outq[$];
    logic [7:0] fb[0:255];
    logic [7:0] pl[0:63];
    bit   prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Randomised downstream backpressure
    always @(negedge clk) if (rnd) m_ready = 1'($urandom_range(0, 1));

    // Monitor sampled 1 time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (prev_stall && (!m_valid || {m_last, m_data} !== prev_word)) stall_bad++;
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
        if (m_valid) mv_cnt++;
        if (m_valid && m_ready) outq.push_back({m_last, m_data});
        if (hdr_valid) hv_cnt++;
        if (hdr_err) he_cnt++;
        if (hdr_valid && hdr_err) both_cnt++;
    end

    task automatic send(input logic [7:0] d, input bit l);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #4;
        while (!s_ready && w < 300) begin
            @(negedge clk);
            #4;
            w++;
        end
        waits += w;
        if (w >= 300) chk("send_timeout", 64'(w), 64'(0));
        @(negedge clk);
    endtask

    task automatic send_frame(input int st, input int n, input bit idle);
        for (int i = 0; i < n; i++) send(fb[st+i], i == n - 1);
        if (idle) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (outq.size() < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        chk("out_count", 64'(outq.size()), 64'(n));
    endtask

    int hv0, he0, mv0, w0;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_hdr_valid", 64'(hdr_valid), 64'(0));
        chk("rst_hdr_err", 64'(hdr_err), 64'(0));
        chk("rst_addr1", 64'(addr1), 64'(0));
        chk("rst_err_code", 64'(err_code), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain data frame, 4 payload bytes
        fb[0] = 8'h08; fb[1] = 8'h00;
        for (int i = 2; i < 24; i++) fb[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 4; i++) fb[24+i] = 8'hA0 + 8'(i);
        hv0 = hv_cnt; outq.delete();
        send_frame(0, 28, 1);
        wait_out(4);
        chk("t1_hv_once", 64'(hv_cnt - hv0), 64'(1));
        chk("t1_fc_ver", 64'(fc_ver), 64'(0));
        chk("t1_fc_type", 64'(fc_type), 64'(2));
        chk("t1_to_ds", 64'(fc_flags[0]), 64'(0));
        chk("t1_dur", 64'(dur_id), 64'h1312);
        chk("t1_addr1", 64'(addr1), 64'h191817161514);
        chk("t1_addr2", 64'(addr2), 64'h1f1e1d1c1b1a);
        chk("t1_addr3", 64'(addr3), 64'h252423222120);
        chk("t1_seq", 64'(seq_ctl), 64'h2726);
        chk("t1_addr4", 64'(addr4), 64'h0);
        for (int k = 0; k < 4; k++)
            if (k < outq.size())
                chk("t1_payload", 64'(outq[k]), 64'({(k == 3), 8'hA0 + 8'(k)}));

        // 2: four-address header, hdr_valid latency, 2 payload bytes
        fb[0] = 8'h08; fb[1] = 8'h03;
        for (int i = 2; i < 30; i++) fb[i] = 8'h40 + 8'(i);
        outq.delete();
        for (int i = 0; i < 29; i++) send(fb[i], 1'b0);
        chk("t2_hv_early", 64'(hdr_valid), 64'(0));
        send(fb[29], 1'b0);
        chk("t2_hv_lat", 64'(hdr_valid), 64'(1));
        chk("t2_addr4", 64'(addr4), 64'h5d5c5b5a5958);
        chk("t2_addr1", 64'(addr1), 64'h494847464544);
        chk("t2_flags", 64'(fc_flags), 64'h03);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_out(2);
        if (outq.size() == 2) begin
            chk("t2_pl0", 64'(outq[0]), 64'h055);
            chk("t2_pl1", 64'(outq[1]), 64'h1AA);
        end

        // 3: runt frame of 10 bytes
        fb[0] = 8'h08; fb[1] = 8'h00;
        for (int i = 2; i < 10; i++) fb[i] = 8'h60 + 8'(i);
        hv0 = hv_cnt; he0 = he_cnt; mv0 = mv_cnt;
        send_frame(0, 10, 1);
        chk("t3_hdr_err", 64'(hdr_err), 64'(1));
        chk("t3_err_code", 64'(err_code), 64'(1));
        repeat (3) @(negedge clk);
        chk("t3_no_hv", 64'(hv_cnt - hv0), 64'(0));
        chk("t3_one_err", 64'(he_cnt - he0), 64'(1));
        chk("t3_no_mv", 64'(mv_cnt - mv0), 64'(0));
        chk("t3_idle_rdy", 64'(s_ready), 64'(1));
        chk("t3_addr1_held", 64'(addr1), 64'h494847464544);

        // 4: bad version, 40-byte frame dropped
        hv0 = hv_cnt; he0 = he_cnt; outq.delete();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        chk("t4_hdr_err", 64'(hdr_err), 64'(1));
        chk("t4_err_code", 64'(err_code), 64'(2));
        w0 = waits;
        for (int i = 2; i < 40; i++) send(8'(i), i == 39);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_stall", 64'(waits - w0), 64'(0));
        chk("t4_no_out", 64'(outq.size()), 64'(0));
        chk("t4_no_hv", 64'(hv_cnt - hv0), 64'(0));
        chk("t4_one_err", 64'(he_cnt - he0), 64'(1));

        // 4b: control frame ends on FC byte 1
        send(8'h04, 1'b0);
        send(8'h00, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        chk("t4b_err_code", 64'(err_code), 64'(3));
        chk("t4b_hdr_err", 64'(hdr_err), 64'(1));
        @(negedge clk);
        chk("t4b_idle_rdy", 64'(s_ready), 64'(1));

        // 4c: header of exactly 24 bytes, no payload
        fb[0] = 8'h88; fb[1] = 8'h01;
        for (int i = 2; i < 24; i++) fb[i] = 8'h70 + 8'(i);
        outq.delete(); he0 = he_cnt;
        send_frame(0, 24, 1);
        chk("t4c_hv", 64'(hdr_valid), 64'(1));
        chk("t4c_subtype", 64'(fc_subtype), 64'(8));
        chk("t4c_flags", 64'(fc_flags), 64'h01);
        chk("t4c_seq", 64'(seq_ctl), 64'h8786);
        repeat (3) @(negedge clk);
        chk("t4c_no_out", 64'(outq.size()), 64'(0));
        chk("t4c_no_err", 64'(he_cnt - he0), 64'(0));

        // 5: 64 payload bytes under random backpressure
        fb[0] = 8'h08; fb[1] = 8'h00;
        for (int i = 2; i < 24; i++) fb[i] = 8'(i);
        for (int i = 0; i < 64; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            fb[24+i] = pl[i];
        end
        outq.delete(); stall_bad = 0; rnd = 1'b1;
        send_frame(0, 88, 1);
        wait_out(64);
        rnd = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 64; k++)
            if (k < outq.size())
                chk("t5_payload", 64'(outq[k]), 64'({(k == 63), pl[k]}));
        chk("t5_stable", 64'(stall_bad), 64'(0));

        // 6: back-to-back frames, reset inside frame 2 payload
        fb[0] = 8'h08; fb[1] = 8'h02;
        for (int i = 2; i < 24; i++) fb[i] = 8'h30 + 8'(i);
        fb[24] = 8'hF1; fb[25] = 8'hF2; fb[26] = 8'hF3;
        fb[27] = 8'h08; fb[28] = 8'h00;
        for (int i = 2; i < 27; i++) fb[27+i] = 8'h90 + 8'(i);
        outq.delete(); hv0 = hv_cnt;
        send_frame(0, 27, 0);
        for (int i = 0; i < 27; i++) send(fb[27+i], 1'b0);
        chk("t6_f2_addr1", 64'(addr1), 64'h999897969594);
        chk("t6_hv_two", 64'(hv_cnt - hv0), 64'(2));
        if (outq.size() >= 3) begin
            chk("t6_f1_pl0", 64'(outq[0]), 64'h0F1);
            chk("t6_f1_pl1", 64'(outq[1]), 64'h0F2);
            chk("t6_f1_pl2", 64'(outq[2]), 64'h1F3);
        end else chk("t6_f1_count", 64'(outq.size()), 64'(3));
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        #1;
        chk("t6_rst_addr1", 64'(addr1), 64'(0));
        chk("t6_rst_m_valid", 64'(m_valid), 64'(0));
        chk("t6_rst_s_ready", 64'(s_ready), 64'(0));
        chk("t6_rst_flags", 64'(fc_flags), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fb[0] = 8'h08; fb[1] = 8'h00;
        for (int i = 2; i < 24; i++) fb[i] = 8'hC0 + 8'(i);
        fb[24] = 8'h3C; fb[25] = 8'hC3;
        outq.delete();
        send_frame(0, 26, 1);
        wait_out(2);
        chk("t6_f3_addr1", 64'(addr1), 64'hc9c8c7c6c5c4);
        chk("t6_f3_seq", 64'(seq_ctl), 64'hd7d6);
        chk("t6_f3_type", 64'(fc_type), 64'(2));
        if (outq.size() == 2) begin
            chk("t6_f3_pl0", 64'(outq[0]), 64'h03C);
            chk("t6_f3_pl1", 64'(outq[1]), 64'h1C3);
        end
        chk("never_both", 64'(both_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
